// File: rtl/fcore_vector_decoder_if.sv
// Handshake bundle between the fetch stream, the fCore vector decoder and the operand fetch stage.
// The master side is the environment (fetch + register file), the slave side is the decoder.
interface fcore_vector_decoder_if #(
    parameter int INSTRUCTION_WIDTH  = 32,
    parameter int OPCODE_WIDTH       = 5,
    parameter int REG_ADDR_WIDTH     = 4,
    parameter int CHANNEL_ADDR_WIDTH = 8
);
    localparam int ADDR_WIDTH = REG_ADDR_WIDTH + CHANNEL_ADDR_WIDTH;

    logic [INSTRUCTION_WIDTH-1:0]  instr_data;
    logic [CHANNEL_ADDR_WIDTH-1:0] instr_dest;
    logic                          instr_valid;
    logic                          instr_ready;

    logic                          op_ready;
    logic                          op_valid;
    logic [OPCODE_WIDTH-1:0]       op_opcode;
    logic [ADDR_WIDTH-1:0]         op_a_addr;
    logic [ADDR_WIDTH-1:0]         op_b_addr;
    logic [ADDR_WIDTH-1:0]         op_c_addr;
    logic [ADDR_WIDTH-1:0]         op_dest;
    logic [INSTRUCTION_WIDTH-1:0]  op_immediate;
    logic                          op_imm_sel;

    modport master (
        output instr_data, instr_dest, instr_valid, op_ready,
        input  instr_ready, op_valid, op_opcode, op_a_addr, op_b_addr, op_c_addr,
               op_dest, op_immediate, op_imm_sel
    );

    modport slave (
        input  instr_data, instr_dest, instr_valid, op_ready,
        output instr_ready, op_valid, op_opcode, op_a_addr, op_b_addr, op_c_addr,
               op_dest, op_immediate, op_imm_sel
    );
endinterface

// File: rtl/fcore_vector_decoder.sv
// fCore vector decoder: one instruction per cycle into channel-offset register addresses,
// with RAW scoreboard stalls, two-word LDC and broadcast replay across channels.
//
// state      | meaning
// S_RUN      | accept and decode instructions
// S_LDC_WAIT | next accepted word is the LDC constant
// S_BCAST    | replay latched instruction on channels 1..n-1
// S_HALT     | STOP seen, wait for enable to drop
module fcore_vector_decoder #(
    parameter int INSTRUCTION_WIDTH  = 32,
    parameter int OPCODE_WIDTH       = 5,
    parameter int REG_ADDR_WIDTH     = 4,
    parameter int CHANNEL_ADDR_WIDTH = 8,
    parameter int IMMEDIATE_WIDTH    = 12,
    parameter int MAX_CHANNELS       = 255,
    parameter int PIPELINE_DEPTH     = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [CHANNEL_ADDR_WIDTH-1:0] n_channels,
    fcore_vector_decoder_if.slave         bus,
    output logic                          hazard_stall,
    output logic                          core_stop
);
    localparam int IW  = INSTRUCTION_WIDTH;
    localparam int OW  = OPCODE_WIDTH;
    localparam int RAW = REG_ADDR_WIDTH;
    localparam int CW  = CHANNEL_ADDR_WIDTH;
    localparam int AW  = REG_ADDR_WIDTH + CHANNEL_ADDR_WIDTH;
    // The op writing back in a given cycle is visible to a read in that same cycle,
    // so only the younger PIPELINE_DEPTH-1 issues can still cause a RAW hazard.
    localparam int SB_DEPTH = (PIPELINE_DEPTH > 1) ? PIPELINE_DEPTH - 1 : 1;

    localparam logic [OW-1:0] OP_NOP    = OW'(0);
    localparam logic [OW-1:0] OP_ADD    = OW'(1);
    localparam logic [OW-1:0] OP_SUB    = OW'(2);
    localparam logic [OW-1:0] OP_MUL    = OW'(3);
    localparam logic [OW-1:0] OP_ITF    = OW'(4);
    localparam logic [OW-1:0] OP_FTI    = OW'(5);
    localparam logic [OW-1:0] OP_LDC    = OW'(6);
    localparam logic [OW-1:0] OP_LDR    = OW'(7);
    localparam logic [OW-1:0] OP_BGT    = OW'(8);
    localparam logic [OW-1:0] OP_BLE    = OW'(9);
    localparam logic [OW-1:0] OP_BEQ    = OW'(10);
    localparam logic [OW-1:0] OP_BNE    = OW'(11);
    localparam logic [OW-1:0] OP_LAND   = OW'(12);
    localparam logic [OW-1:0] OP_LOR    = OW'(13);
    localparam logic [OW-1:0] OP_LNOT   = OW'(14);
    localparam logic [OW-1:0] OP_LXOR   = OW'(15);
    localparam logic [OW-1:0] OP_SATP   = OW'(16);
    localparam logic [OW-1:0] OP_SATN   = OW'(17);
    localparam logic [OW-1:0] OP_REC    = OW'(18);
    localparam logic [OW-1:0] OP_POPCNT = OW'(19);
    localparam logic [OW-1:0] OP_ABS    = OW'(20);
    localparam logic [OW-1:0] OP_BSET   = OW'(21);
    localparam logic [OW-1:0] OP_BSEL   = OW'(22);
    localparam logic [OW-1:0] OP_STOP   = OW'(31);

    typedef enum logic [1:0] {S_RUN, S_LDC_WAIT, S_BCAST, S_HALT} state_t;
    state_t state_q, state_d;

    logic [OW-1:0]              held_opc;
    logic [RAW-1:0]             held_a, held_b, held_d;
    logic [IMMEDIATE_WIDTH-1:0] held_immf;
    logic                       held_bflag;
    logic [CW-1:0]              held_dest;
    logic [IW-1:0]              held_const;
    logic [CW-1:0]              bc_cnt, bc_last, n_eff;

    logic [OW-1:0]              c_opc;
    logic [RAW-1:0]             c_a, c_b, c_d;
    logic [IMMEDIATE_WIDTH-1:0] c_immf;
    logic                       c_bflag;
    logic [CW-1:0]              c_chan;
    logic [IW-1:0]              c_const;

    logic is_3op, is_bset, is_2op, is_ldr, is_ldc, is_stop;
    logic use_a, use_b, use_c, c_issue, c_imm_sel;
    logic [AW-1:0] c_a_addr, c_b_addr, c_c_addr, c_dest;
    logic [IW-1:0] c_imm;

    logic [SB_DEPTH-1:0] sb_valid;
    logic [AW-1:0]       sb_dest [SB_DEPTH];

    logic hazard, slot_free, accepting, instr_ready, fire, bc_go, issue;
    logic load_held, load_const, start_bc, stop_d;

    logic            op_valid_q, op_imm_sel_q;
    logic [OW-1:0]   op_opcode_q;
    logic [AW-1:0]   op_a_q, op_b_q, op_c_q, op_dest_q;
    logic [IW-1:0]   op_imm_q;

    always_comb begin
        n_eff = n_channels;
        if (n_channels == '0)
            n_eff = CW'(1);
        else if (int'(n_channels) > MAX_CHANNELS)
            n_eff = CW'(MAX_CHANNELS);
    end

    // Candidate comes from the bus in RUN, from the latched instruction otherwise.
    always_comb begin
        c_opc   = bus.instr_data[OW-1:0];
        c_a     = bus.instr_data[OW +: RAW];
        c_b     = bus.instr_data[OW+RAW +: RAW];
        c_d     = bus.instr_data[OW+2*RAW +: RAW];
        c_immf  = bus.instr_data[OW+RAW +: IMMEDIATE_WIDTH];
        c_bflag = bus.instr_data[IW-1];
        c_chan  = c_bflag ? '0 : bus.instr_dest;
        c_const = held_const;
        if (state_q == S_LDC_WAIT || state_q == S_BCAST) begin
            c_opc   = held_opc;
            c_a     = held_a;
            c_b     = held_b;
            c_d     = held_d;
            c_immf  = held_immf;
            c_bflag = held_bflag;
            if (state_q == S_BCAST) begin
                c_chan = bc_cnt;
            end else begin
                c_chan  = held_bflag ? '0 : held_dest;
                c_const = bus.instr_data;
            end
        end
    end

    always_comb begin
        is_3op  = 1'b0;
        is_bset = 1'b0;
        is_2op  = 1'b0;
        is_ldr  = 1'b0;
        is_ldc  = 1'b0;
        is_stop = 1'b0;
        case (c_opc)
            OP_ADD, OP_SUB, OP_MUL, OP_BGT, OP_BLE, OP_BEQ, OP_BNE,
            OP_LAND, OP_LOR, OP_LXOR, OP_BSEL, OP_SATP, OP_SATN: is_3op = 1'b1;
            OP_BSET:                                             is_bset = 1'b1;
            OP_REC, OP_FTI, OP_ITF, OP_ABS, OP_POPCNT, OP_LNOT:  is_2op = 1'b1;
            OP_LDR:                                              is_ldr = 1'b1;
            OP_LDC:                                              is_ldc = 1'b1;
            OP_STOP:                                             is_stop = 1'b1;
            OP_NOP:                                              ;
            default:                                             ;
        endcase
    end

    always_comb begin
        c_a_addr  = '0;
        c_b_addr  = '0;
        c_c_addr  = '0;
        c_dest    = '0;
        c_imm     = '0;
        c_imm_sel = 1'b0;
        use_a     = 1'b0;
        use_b     = 1'b0;
        use_c     = 1'b0;
        c_issue   = 1'b0;
        if (is_3op) begin
            c_issue  = 1'b1;
            use_a    = 1'b1;
            use_b    = 1'b1;
            c_a_addr = {c_chan, c_a};
            c_b_addr = {c_chan, c_b};
            c_dest   = {c_chan, c_d};
        end else if (is_bset) begin
            c_issue  = 1'b1;
            use_a    = 1'b1;
            use_b    = 1'b1;
            use_c    = 1'b1;
            c_a_addr = {c_chan, c_a};
            c_b_addr = {c_chan, c_b};
            c_c_addr = {c_chan, c_d};
            c_dest   = {c_chan, c_a};
        end else if (is_2op) begin
            c_issue  = 1'b1;
            use_a    = 1'b1;
            c_a_addr = {c_chan, c_a};
            c_dest   = {c_chan, c_b};
        end else if (is_ldr) begin
            c_issue   = 1'b1;
            c_dest    = {c_chan, c_a};
            c_imm     = IW'(c_immf);
            c_imm_sel = 1'b1;
        end else if (is_ldc) begin
            // First LDC word in RUN only opens the constant slot.
            c_issue   = (state_q != S_RUN);
            c_dest    = {c_chan, c_a};
            c_imm     = c_const;
            c_imm_sel = 1'b1;
        end
    end

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_valid[i] && ((use_a && sb_dest[i] == c_a_addr) ||
                                (use_b && sb_dest[i] == c_b_addr) ||
                                (use_c && sb_dest[i] == c_c_addr)))
                hazard = 1'b1;
        end
    end

    assign slot_free   = !op_valid_q || bus.op_ready;
    assign accepting   = (state_q == S_RUN) || (state_q == S_LDC_WAIT);
    assign instr_ready = !reset && enable && accepting && !hazard && slot_free;
    assign fire        = bus.instr_valid && instr_ready;
    assign bc_go       = (state_q == S_BCAST) && enable && slot_free && !hazard;
    assign issue       = (fire && c_issue) || bc_go;
    assign hazard_stall = !reset && enable && slot_free && hazard &&
                          ((accepting && bus.instr_valid) || state_q == S_BCAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state_q <= S_RUN;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_held  = 1'b0;
        load_const = 1'b0;
        start_bc   = 1'b0;
        stop_d     = 1'b0;
        case (state_q)
            S_RUN: begin
                if (fire) begin
                    if (is_ldc) begin
                        load_held = 1'b1;
                        state_d   = S_LDC_WAIT;
                    end else if (is_stop) begin
                        stop_d  = 1'b1;
                        state_d = S_HALT;
                    end else if (c_issue && c_bflag && n_eff > CW'(1)) begin
                        load_held = 1'b1;
                        start_bc  = 1'b1;
                        state_d   = S_BCAST;
                    end
                end
            end
            S_LDC_WAIT: begin
                if (fire) begin
                    if (held_bflag && n_eff > CW'(1)) begin
                        load_const = 1'b1;
                        start_bc   = 1'b1;
                        state_d    = S_BCAST;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_BCAST: begin
                if (bc_go && bc_cnt == bc_last)
                    state_d = S_RUN;
            end
            S_HALT: begin
                if (!enable)
                    state_d = S_RUN;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            core_stop    <= 1'b0;
            held_opc     <= '0;
            held_a       <= '0;
            held_b       <= '0;
            held_d       <= '0;
            held_immf    <= '0;
            held_bflag   <= 1'b0;
            held_dest    <= '0;
            held_const   <= '0;
            bc_cnt       <= '0;
            bc_last      <= '0;
            op_valid_q   <= 1'b0;
            op_opcode_q  <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_c_q       <= '0;
            op_dest_q    <= '0;
            op_imm_q     <= '0;
            op_imm_sel_q <= 1'b0;
            sb_valid     <= '0;
            for (int i = 0; i < SB_DEPTH; i++)
                sb_dest[i] <= '0;
        end else begin
            core_stop <= stop_d;
            if (load_held) begin
                held_opc   <= c_opc;
                held_a     <= c_a;
                held_b     <= c_b;
                held_d     <= c_d;
                held_immf  <= c_immf;
                held_bflag <= c_bflag;
                held_dest  <= bus.instr_dest;
            end
            if (load_const)
                held_const <= bus.instr_data;
            if (start_bc) begin
                bc_cnt  <= CW'(1);
                bc_last <= n_eff - CW'(1);
            end else if (bc_go) begin
                bc_cnt <= bc_cnt + CW'(1);
            end
            if (issue) begin
                op_valid_q   <= 1'b1;
                op_opcode_q  <= c_opc;
                op_a_q       <= c_a_addr;
                op_b_q       <= c_b_addr;
                op_c_q       <= c_c_addr;
                op_dest_q    <= c_dest;
                op_imm_q     <= c_imm;
                op_imm_sel_q <= c_imm_sel;
            end else if (bus.op_ready) begin
                op_valid_q <= 1'b0;
            end
            sb_valid[0] <= issue;
            sb_dest[0]  <= issue ? c_dest : '0;
            for (int i = 1; i < SB_DEPTH; i++) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_dest[i]  <= sb_dest[i-1];
            end
        end
    end

    assign bus.instr_ready  = instr_ready;
    assign bus.op_valid     = op_valid_q;
    assign bus.op_opcode    = op_opcode_q;
    assign bus.op_a_addr    = op_a_q;
    assign bus.op_b_addr    = op_b_q;
    assign bus.op_c_addr    = op_c_q;
    assign bus.op_dest      = op_dest_q;
    assign bus.op_immediate = op_imm_q;
    assign bus.op_imm_sel   = op_imm_sel_q;
endmodule

// File: tb/tb_fcore_vector_decoder.sv
// Directed-vector bench for fcore_vector_decoder with hand-computed expectations.
module tb_fcore_vector_decoder;
    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_MUL  = 5'd3;
    localparam logic [4:0] OP_LDC  = 5'd6;
    localparam logic [4:0] OP_LDR  = 5'd7;
    localparam logic [4:0] OP_ABS  = 5'd20;
    localparam logic [4:0] OP_BSET = 5'd21;
    localparam logic [4:0] OP_STOP = 5'd31;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] n_channels;
    logic       hazard_stall;
    logic       core_stop;

    int n_tests = 0;
    int n_fail  = 0;

    fcore_vector_decoder_if bus ();

    fcore_vector_decoder dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .n_channels   (n_channels),
        .bus          (bus),
        .hazard_stall (hazard_stall),
        .core_stop    (core_stop)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic bf, input logic [4:0] opc,
                                        input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] d);
        return {bf, 14'd0, d, b, a, opc};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Called just after a rising edge; returns just after the edge following acceptance.
    task automatic send(input string tag, input logic [31:0] data, input logic [7:0] ch,
                        output int waits, output int hz);
        logic rdy;
        logic acc;
        acc   = 1'b0;
        waits = 0;
        hz    = 0;
        bus.instr_data  = data;
        bus.instr_dest  = ch;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            rdy = bus.instr_ready;
            if (!rdy) begin
                waits++;
                if (hazard_stall) hz++;
            end
            @(posedge clock);
            #1;
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        bus.instr_valid = 1'b0;
        check_eq({"accept_", tag}, 32'(acc), 32'd1);
    endtask

    int w, h;

    initial begin
        reset           = 1'b1;
        enable          = 1'b0;
        n_channels      = 8'd1;
        bus.instr_data  = '0;
        bus.instr_dest  = '0;
        bus.instr_valid = 1'b0;
        bus.op_ready    = 1'b0;
        repeat (3) tick();

        @(negedge clock);
        check_eq("rst_op_valid", 32'(bus.op_valid), 0);
        check_eq("rst_instr_ready", 32'(bus.instr_ready), 0);
        check_eq("rst_op_dest", 32'(bus.op_dest), 0);
        check_eq("rst_hazard", 32'(hazard_stall), 0);
        check_eq("rst_core_stop", 32'(core_stop), 0);
        tick();
        reset        = 1'b0;
        enable       = 1'b1;
        bus.op_ready = 1'b1;
        tick();

        // Basic 3-operand decode on channel 2
        send("add", ins(1'b0, OP_ADD, 4'd1, 4'd2, 4'd3), 8'd2, w, h);
        @(negedge clock);
        check_eq("add_valid", 32'(bus.op_valid), 1);
        check_eq("add_a", 32'(bus.op_a_addr), 'h21);
        check_eq("add_b", 32'(bus.op_b_addr), 'h22);
        check_eq("add_dest", 32'(bus.op_dest), 'h23);
        check_eq("add_hazard", 32'(hazard_stall), 0);
        repeat (6) tick();

        // RAW hazard: SUB reads the ADD result
        send("haz_add", ins(1'b0, OP_ADD, 4'd1, 4'd2, 4'd3), 8'd2, w, h);
        send("haz_sub", ins(1'b0, OP_SUB, 4'd3, 4'd5, 4'd6), 8'd2, w, h);
        check_eq("haz_wait_cycles", 32'(w), 3);
        check_eq("haz_stall_cycles", 32'(h), 3);
        @(negedge clock);
        check_eq("haz_sub_valid", 32'(bus.op_valid), 1);
        check_eq("haz_sub_a", 32'(bus.op_a_addr), 'h23);
        check_eq("haz_sub_b", 32'(bus.op_b_addr), 'h25);
        check_eq("haz_sub_dest", 32'(bus.op_dest), 'h26);
        tick();

        // Two-word LDC on channel 1
        send("ldc_w0", ins(1'b0, OP_LDC, 4'd5, 4'd0, 4'd0), 8'd1, w, h);
        @(negedge clock);
        check_eq("ldc_no_issue", 32'(bus.op_valid), 0);
        tick();
        send("ldc_w1", 32'hDEADBEEF, 8'd0, w, h);
        @(negedge clock);
        check_eq("ldc_valid", 32'(bus.op_valid), 1);
        check_eq("ldc_opcode", 32'(bus.op_opcode), 32'(OP_LDC));
        check_eq("ldc_dest", 32'(bus.op_dest), 'h15);
        check_eq("ldc_imm", bus.op_immediate, 32'hDEADBEEF);
        check_eq("ldc_imm_sel", 32'(bus.op_imm_sel), 1);
        tick();

        // LDR immediate 0xABC to reg 2 of channel 3
        send("ldr", {1'b0, 10'd0, 12'hABC, 4'd2, OP_LDR}, 8'd3, w, h);
        @(negedge clock);
        check_eq("ldr_dest", 32'(bus.op_dest), 'h32);
        check_eq("ldr_imm", bus.op_immediate, 'hABC);
        check_eq("ldr_imm_sel", 32'(bus.op_imm_sel), 1);
        tick();

        // BSET: c source is d, destination is a
        send("bset", ins(1'b0, OP_BSET, 4'd1, 4'd2, 4'd3), 8'd5, w, h);
        @(negedge clock);
        check_eq("bset_a", 32'(bus.op_a_addr), 'h51);
        check_eq("bset_b", 32'(bus.op_b_addr), 'h52);
        check_eq("bset_c", 32'(bus.op_c_addr), 'h53);
        check_eq("bset_dest", 32'(bus.op_dest), 'h51);
        check_eq("bset_imm_sel", 32'(bus.op_imm_sel), 0);
        tick();

        send("nop", ins(1'b0, OP_NOP, 4'd1, 4'd1, 4'd1), 8'd5, w, h);
        @(negedge clock);
        check_eq("nop_no_issue", 32'(bus.op_valid), 0);
        repeat (4) tick();

        // Broadcast ABS over 3 channels
        n_channels = 8'd3;
        send("bc_abs", ins(1'b1, OP_ABS, 4'd4, 4'd6, 4'd0), 8'd7, w, h);
        bus.instr_data  = ins(1'b0, OP_NOP, 4'd0, 4'd0, 4'd0);
        bus.instr_valid = 1'b1;
        for (int ch = 0; ch < 3; ch++) begin
            @(negedge clock);
            check_eq($sformatf("bc_valid_%0d", ch), 32'(bus.op_valid), 1);
            check_eq($sformatf("bc_a_%0d", ch), 32'(bus.op_a_addr), 32'(ch * 16 + 4));
            check_eq($sformatf("bc_dest_%0d", ch), 32'(bus.op_dest), 32'(ch * 16 + 6));
            check_eq($sformatf("bc_ready_%0d", ch), 32'(bus.instr_ready), (ch == 2) ? 1 : 0);
            tick();
        end
        bus.instr_valid = 1'b0;
        n_channels = 8'd1;
        repeat (4) tick();

        // Downstream backpressure for 5 cycles
        bus.op_ready = 1'b0;
        send("bp_add", ins(1'b0, OP_ADD, 4'd1, 4'd2, 4'd3), 8'd4, w, h);
        bus.instr_data  = ins(1'b0, OP_MUL, 4'd7, 4'd8, 4'd9);
        bus.instr_dest  = 8'd4;
        bus.instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq($sformatf("bp_valid_%0d", i), 32'(bus.op_valid), 1);
            check_eq($sformatf("bp_a_%0d", i), 32'(bus.op_a_addr), 'h41);
            check_eq($sformatf("bp_dest_%0d", i), 32'(bus.op_dest), 'h43);
            check_eq($sformatf("bp_ready_%0d", i), 32'(bus.instr_ready), 0);
            tick();
        end
        bus.op_ready = 1'b1;
        @(negedge clock);
        check_eq("bp_release_ready", 32'(bus.instr_ready), 1);
        check_eq("bp_release_dest", 32'(bus.op_dest), 'h43);
        tick();
        bus.instr_valid = 1'b0;
        @(negedge clock);
        check_eq("bp_next_valid", 32'(bus.op_valid), 1);
        check_eq("bp_next_opcode", 32'(bus.op_opcode), 32'(OP_MUL));
        check_eq("bp_next_dest", 32'(bus.op_dest), 'h49);
        repeat (4) tick();

        // STOP and HALT release
        send("stop", ins(1'b0, OP_STOP, 4'd0, 4'd0, 4'd0), 8'd0, w, h);
        @(negedge clock);
        check_eq("stop_pulse", 32'(core_stop), 1);
        check_eq("stop_ready0", 32'(bus.instr_ready), 0);
        tick();
        @(negedge clock);
        check_eq("stop_pulse_end", 32'(core_stop), 0);
        check_eq("halt_ready", 32'(bus.instr_ready), 0);
        tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        @(negedge clock);
        check_eq("halt_exit_ready", 32'(bus.instr_ready), 1);
        repeat (4) tick();

        // Reset during broadcast
        n_channels = 8'd4;
        send("bc_rst", ins(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3), 8'd9, w, h);
        @(negedge clock);
        check_eq("bcr_ch0_valid", 32'(bus.op_valid), 1);
        check_eq("bcr_ch0_dest", 32'(bus.op_dest), 'h03);
        #2;
        reset = 1'b1;
        #1;
        check_eq("bcr_rst_valid", 32'(bus.op_valid), 0);
        check_eq("bcr_rst_ready", 32'(bus.instr_ready), 0);
        check_eq("bcr_rst_dest", 32'(bus.op_dest), 0);
        check_eq("bcr_rst_a", 32'(bus.op_a_addr), 0);
        check_eq("bcr_rst_hazard", 32'(hazard_stall), 0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clock);
        check_eq("bcr_run_ready", 32'(bus.instr_ready), 1);
        check_eq("bcr_no_replay0", 32'(bus.op_valid), 0);
        tick();
        @(negedge clock);
        check_eq("bcr_no_replay1", 32'(bus.op_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
